// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states
// and small byte-lane helpers.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            SZ_WORD: size_bytes = 3'd4;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    // Byte lane pos of a right-justified word (pos 0 = bits [7:0])
    function automatic logic [7:0] store_byte(input logic [31:0] w, input logic [1:0] pos);
        case (pos)
            2'd0:    store_byte = w[7:0];
            2'd1:    store_byte = w[15:8];
            2'd2:    store_byte = w[23:16];
            2'd3:    store_byte = w[31:24];
            default: store_byte = w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Turns the right-justified big-endian load field into the 32-bit load result
// with sign or zero extension for byte and halfword loads.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] field,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] rdata
);

    // Extend the byte/half field to a full word
    always_comb begin
        rdata = field;
        case (size)
            SZ_BYTE: rdata = is_unsigned ? {24'h000000, field[7:0]}
                                         : {{24{field[7]}}, field[7:0]};
            SZ_HALF: rdata = is_unsigned ? {16'h0000, field[15:0]}
                                         : {{16{field[15]}}, field[15:0]};
            default: rdata = field;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: serialises each request into big-endian byte
// transactions. Define MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_e            state_r;
    logic              we_r;
    logic              unsigned_r;
    logic [1:0]        size_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [31:0]       field_r;
    logic [2:0]        nbytes_r;
    logic [2:0]        byte_idx_r;
    logic [WAIT_W-1:0] wait_cnt_r;

    logic [2:0]        req_nbytes_s;
    logic              misalign_s;
    logic              pre_fault_s;
    logic [1:0]        pos_s;
    logic              last_byte_s;
    logic              timeout_s;
    logic [31:0]       field_next_s;
    logic [31:0]       ext_rdata_s;

    assign req_nbytes_s = size_bytes(req_size);

`ifdef MISALIGN_TRAP_EN
    assign misalign_s = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misalign_s = 1'b0;
`endif

    assign pre_fault_s = (req_size == SZ_ILL) || (|req_addr[31:ADDR_W]) || misalign_s;
    // Lane of the current byte inside the N-byte field (byte 0 is the MSB lane)
    assign pos_s       = 2'(nbytes_r - byte_idx_r - 3'd1);
    assign last_byte_s = (byte_idx_r == (nbytes_r - 3'd1));
    assign timeout_s   = (wait_cnt_r == WAIT_W'(TIMEOUT - 1));

    // Drop the byte being acked into its lane of the load field
    always_comb begin
        field_next_s = field_r;
        field_next_s[{pos_s, 3'b000} +: 8] = mem_rdata;
    end

    lsu_load_extend u_load_extend (
        .field       (field_next_s),
        .size        (size_r),
        .is_unsigned (unsigned_r),
        .rdata       (ext_rdata_s)
    );

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= 32'h0000_0000;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'h00;
            we_r       <= 1'b0;
            unsigned_r <= 1'b0;
            size_r     <= SZ_BYTE;
            addr_r     <= '0;
            wdata_r    <= 32'h0000_0000;
            field_r    <= 32'h0000_0000;
            nbytes_r   <= 3'd0;
            byte_idx_r <= 3'd0;
            wait_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        we_r       <= req_we;
                        unsigned_r <= req_unsigned;
                        size_r     <= req_size;
                        addr_r     <= req_addr[ADDR_W-1:0];
                        wdata_r    <= req_wdata;
                        nbytes_r   <= req_nbytes_s;
                        field_r    <= 32'h0000_0000;
                        byte_idx_r <= 3'd0;
                        wait_cnt_r <= '0;
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                        if (pre_fault_s) begin
                            state_r <= ST_RESP;
                        end else begin
                            state_r   <= ST_ACCESS;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= req_addr[ADDR_W-1:0];
                            mem_wdata <= store_byte(req_wdata, 2'(req_nbytes_s - 3'd1));
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        field_r    <= field_next_s;
                        wait_cnt_r <= '0;
                        if (last_byte_s) begin
                            state_r    <= ST_RESP;
                            mem_req    <= 1'b0;
                            mem_we     <= 1'b0;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b0;
                            resp_rdata <= we_r ? 32'h0000_0000 : ext_rdata_s;
                        end else begin
                            byte_idx_r <= byte_idx_r + 3'd1;
                            mem_addr   <= addr_r + ADDR_W'(byte_idx_r + 3'd1);
                            mem_wdata  <= store_byte(wdata_r, pos_s - 2'd1);
                        end
                    end else if (timeout_s) begin
                        state_r    <= ST_RESP;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b1;
                        resp_rdata <= 32'h0000_0000;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                ST_RESP: begin
                    // Entered without the pulse only from a pre-check fault
                    if (resp_valid) begin
                        state_r    <= ST_IDLE;
                        resp_valid <= 1'b0;
                        resp_fault <= 1'b0;
                        resp_rdata <= 32'h0000_0000;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b1;
                        resp_rdata <= 32'h0000_0000;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    mem_req    <= 1'b0;
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level reference model,
// per-cycle output comparison, directed cases and randomized traffic.
module tb_load_store_unit;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault, busy;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_mem [0:1023];
    logic [7:0] dut_mem [0:1023];

    // Expected outputs for the current cycle, set by the driver
    logic        check_en = 1'b0;
    logic        e_ready, e_busy, e_mreq, e_mwe, e_rvalid, e_fault;
    logic [9:0]  e_maddr;
    logic [7:0]  e_mwdata;
    logic [31:0] e_rdata;

    logic [31:0] last_rdata;
    logic        last_fault;
    int          last_lat;
    int          plan_wait [4];
    int          plan_to;
    int          plan_rst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory as the DUT actually writes it
    always @(posedge clk) begin
        if (mem_req && mem_ack && mem_we)
            dut_mem[mem_addr] <= mem_wdata;
    end

    // Compare every output against the model each cycle
    always @(negedge clk) begin
        if (check_en) begin
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("mem_req", 32'(mem_req), 32'(e_mreq));
            chk("resp_valid", 32'(resp_valid), 32'(e_rvalid));
            if (e_mreq) begin
                chk("mem_addr", 32'(mem_addr), 32'(e_maddr));
                chk("mem_we", 32'(mem_we), 32'(e_mwe));
                if (e_mwe) chk("mem_wdata", 32'(mem_wdata), 32'(e_mwdata));
            end
            if (e_rvalid) begin
                chk("resp_fault", 32'(resp_fault), 32'(e_fault));
                chk("resp_rdata", resp_rdata, e_rdata);
                last_rdata = resp_rdata;
                last_fault = resp_fault;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        e_ready = 1'b1; e_busy = 1'b0; e_mreq = 1'b0; e_rvalid = 1'b0;
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 4; i++) plan_wait[i] = 0;
        plan_to  = -1;
        plan_rst = -1;
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] f, input logic [1:0] size,
                                               input logic uns);
        if (size == 2'd2) return f;
        if (size == 2'd1) return uns ? (f & 32'h0000_FFFF) : 32'($signed(f[15:0]));
        return uns ? (f & 32'h0000_00FF) : 32'($signed(f[7:0]));
    endfunction

    // One request from accept to the idle cycle after the response
    task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int n, lat, nw;
        logic fault, timed_out;
        logic [31:0] field;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        fault = (size == 2'd3) || (addr >= 32'd1024);
`ifdef MISALIGN_TRAP_EN
        if ((size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00)) fault = 1'b1;
`endif
        timed_out = 1'b0;
        field = 32'h0;
        lat = 0;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; mem_ack = 1'($urandom);
        set_idle();
        step(); lat++;
        req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        e_ready = 1'b0; e_busy = 1'b1; e_rvalid = 1'b0;
        if (fault) begin
            e_mreq = 1'b0; mem_ack = 1'($urandom);
            step(); lat++;
        end else begin
            for (int i = 0; i < n; i++) begin
                e_mreq = 1'b1; e_mwe = we;
                e_maddr = 10'(addr + 32'(i));
                e_mwdata = wdata[8*(n-1-i) +: 8];
                if (i == plan_rst) begin
                    rst = 1'b1; mem_ack = 1'b0;
                    step();
                    rst = 1'b0; req_valid = 1'b0;
                    set_idle();
                    return;
                end
                nw = (i == plan_to) ? TIMEOUT : plan_wait[i];
                for (int w = 0; w < nw; w++) begin
                    mem_ack = 1'b0; mem_rdata = 8'($urandom);
                    step(); lat++;
                end
                if (i == plan_to) begin
                    timed_out = 1'b1;
                    break;
                end
                mem_ack = 1'b1;
                if (we) ref_mem[e_maddr] = e_mwdata;
                else begin
                    mem_rdata = ref_mem[e_maddr];
                    field = {field[23:0], mem_rdata};
                end
                step(); lat++;
            end
        end
        e_mreq = 1'b0; e_rvalid = 1'b1;
        if (fault || timed_out) begin
            e_fault = 1'b1; e_rdata = 32'h0;
        end else begin
            e_fault = 1'b0;
            e_rdata = we ? 32'h0 : model_load(field, size, uns);
        end
        last_lat = lat;
        mem_ack = 1'($urandom);
        step();
        req_valid = 1'b0;
        set_idle();
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  old42;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = 8'($urandom);
            dut_mem[i] = ref_mem[i];
        end
        clear_plan();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 8'h00;
        e_fault = 1'b0; e_rdata = 32'h0; e_mwe = 1'b0; e_maddr = 10'h0; e_mwdata = 8'h0;
        last_rdata = 32'h0; last_fault = 1'b0; last_lat = 0;
        step(); step();
        rst = 1'b0;
        set_idle();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_fault", 32'(resp_fault), 32'd0);
        chk("rst_maddr", 32'(mem_addr), 32'd0);
        chk("rst_mwdata", 32'(mem_wdata), 32'd0);
        chk("rst_mwe", 32'(mem_we), 32'd0);
        check_en = 1'b1;
        step();

        do_txn(1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF);
        chk("sw_latency", 32'(last_lat), 32'd5);
        chk("sw_byte0", 32'(dut_mem[10'h010]), 32'hDE);
        chk("sw_byte1", 32'(dut_mem[10'h011]), 32'hAD);
        chk("sw_byte2", 32'(dut_mem[10'h012]), 32'hBE);
        chk("sw_byte3", 32'(dut_mem[10'h013]), 32'hEF);
        do_txn(1'b0, 2'd0, 1'b0, 32'h013, 32'h0);
        chk("lb_signed", last_rdata, 32'hFFFF_FFEF);
        do_txn(1'b0, 2'd0, 1'b1, 32'h013, 32'h0);
        chk("lbu", last_rdata, 32'h0000_00EF);
        do_txn(1'b0, 2'd1, 1'b0, 32'h010, 32'h0);
        chk("lh_signed", last_rdata, 32'hFFFF_DEAD);

        ref_mem[10'h3FE] = 8'h11; ref_mem[10'h3FF] = 8'h22;
        ref_mem[10'h000] = 8'h33; ref_mem[10'h001] = 8'h44;
        do_txn(1'b0, 2'd2, 1'b0, 32'h3FE, 32'h0);
`ifdef MISALIGN_TRAP_EN
        chk("lw_wrap_fault", 32'(last_fault), 32'd1);
`else
        chk("lw_wrap", last_rdata, 32'h1122_3344);
`endif

        clear_plan(); plan_to = 1;
        do_txn(1'b0, 2'd2, 1'b0, 32'h020, 32'h0);
        chk("timeout_fault", 32'(last_fault), 32'd1);
        chk("timeout_rdata", last_rdata, 32'h0);
        chk("timeout_latency", 32'(last_lat), 32'd17);
        clear_plan();

        do_txn(1'b0, 2'd3, 1'b0, 32'h030, 32'h0);
        chk("illegal_size_latency", 32'(last_lat), 32'd2);
        do_txn(1'b1, 2'd0, 1'b0, 32'h400, 32'h55);
        chk("range_fault", 32'(last_fault), 32'd1);
        chk("range_latency", 32'(last_lat), 32'd2);

        old42 = ref_mem[10'h042];
        plan_rst = 2;
        do_txn(1'b1, 2'd2, 1'b0, 32'h040, 32'h12345678);
        clear_plan();
        step();
        chk("rst_mid_b0", 32'(dut_mem[10'h040]), 32'h12);
        chk("rst_mid_b1", 32'(dut_mem[10'h041]), 32'h34);
        chk("rst_mid_b2", 32'(dut_mem[10'h042]), 32'(old42));

        for (int t = 0; t < 200; t++) begin
            clear_plan();
            case ($urandom_range(0, 9))
                0:       a = 32'h400 + $urandom_range(0, 4000);
                1:       a = 32'h3FC + $urandom_range(0, 3);
                default: a = $urandom_range(0, 1023);
            endcase
            for (int i = 0; i < 4; i++)
                plan_wait[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            if ($urandom_range(0, 11) == 0) plan_to = $urandom_range(0, 3);
            do_txn(1'($urandom),
                   ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                   1'($urandom), a, $urandom);
            repeat ($urandom_range(0, 2)) begin
                mem_ack = 1'($urandom);
                step();
            end
        end

        begin
            int diffs = 0;
            for (int i = 0; i < 1024; i++)
                if (dut_mem[i] !== ref_mem[i]) diffs++;
            chk("memory_image_diffs", 32'(diffs), 32'd0);
        end

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
